// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the recovery-PLL dynamic phase controller:
// sequencer state encodings, PLL output indices and sizing helpers.
package pll_ctrl_pkg;

   localparam logic [3:0] ST_WAIT_LOCK = 4'd0;
   localparam logic [3:0] ST_IDLE      = 4'd1;
   localparam logic [3:0] ST_SETUP     = 4'd2;
   localparam logic [3:0] ST_STEP_LO   = 4'd3;
   localparam logic [3:0] ST_STEP_HI   = 4'd4;
   localparam logic [3:0] ST_LOAD_LO   = 4'd5;
   localparam logic [3:0] ST_LOAD_HI   = 4'd6;
   localparam logic [3:0] ST_SETTLE    = 4'd7;
   localparam logic [3:0] ST_DONE      = 4'd8;

   localparam logic [1:0] OUT_CLKOP  = 2'd0;
   localparam logic [1:0] OUT_CLKOS  = 2'd1;
   localparam logic [1:0] OUT_CLKOS2 = 2'd2;
   localparam logic [1:0] OUT_CLKOS3 = 2'd3;

   // Bits per phase position; never narrower than one bit.
   function automatic int pw_of(input int phase_mod);
      return (phase_mod > 1) ? $clog2(phase_mod) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-shift request channel from the recovery-clock alignment logic
// to the PLL phase controller (valid/ready handshake).
interface pll_phase_ctrl_if #(
   parameter int STEP_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_sel;
   logic              req_dir;
   logic [STEP_W-1:0] req_steps;

   modport master (output req_valid, output req_sel, output req_dir, output req_steps,
                   input req_ready);
   modport slave  (input req_valid, input req_sel, input req_dir, input req_steps,
                   output req_ready);
endinterface

// File: rtl/lock_filter.sv
// Synchronises the asynchronous PLL LOCK pin and qualifies it as stable
// only after LOCK_STABLE consecutive high cycles.
module lock_filter #(
   parameter int LOCK_STABLE = 1024
) (
   input  logic clk_16mhz,
   input  logic rst_n,
   input  logic pll_lock,
   output logic lock_ok
);
   localparam int             CW      = $clog2(LOCK_STABLE + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_STABLE);

   logic          sync1_r;
   logic          sync2_r;
   logic [CW-1:0] cnt_r;

   // Two-flop synchroniser for the lock pin
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= pll_lock;
         sync2_r <= sync1_r;
      end
   end

   // Saturating stability counter, cleared by any low sample
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (!sync2_r) begin
         cnt_r <= {CW{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign lock_ok = (cnt_r == CNT_MAX);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Drives the EHXPLLL dynamic-phase pins to shift one PLL output by N fine
// steps per accepted request, gated on a debounced lock; tracks all positions.
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int STEP_W      = 8,
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 4,
   parameter int LOCK_STABLE = 1024,
   parameter int SETTLE_CYC  = 256,
   parameter int PHASE_MOD   = 8,
   localparam int PW         = pw_of(PHASE_MOD)
) (
   input  logic              clk_16mhz,
   input  logic              rst_n,
   pll_phase_ctrl_if.slave   req,
   input  logic              pll_lock,
   output logic [1:0]        phasesel,
   output logic              phasedir,
   output logic              phasestep,
   output logic              phaseloadreg,
   output logic              lock_ok,
   output logic              done,
   output logic              err_unlock,
   output logic [4*PW-1:0]   phase_pos
);
   localparam int            TW       = $clog2(max3(PULSE_CYC, GAP_CYC, SETTLE_CYC) + 1);
   localparam logic [TW-1:0] T_PULSE  = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] T_GAP    = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYC - 1);
   localparam logic [PW-1:0] POS_MAX  = PW'(PHASE_MOD - 1);

   logic [3:0]        state_r;
   logic [TW-1:0]     tmr_r;
   logic [STEP_W-1:0] rem_r;
   logic [PW-1:0]     pos_r [4];

   // Compare before stepping so PHASE_MOD need not be a power of two.
   function automatic logic [PW-1:0] pos_step(input logic [PW-1:0] p, input logic lag);
      if (lag) begin
         return (p == POS_MAX) ? {PW{1'b0}} : p + PW'(1);
      end else begin
         return (p == {PW{1'b0}}) ? POS_MAX : p - PW'(1);
      end
   endfunction

   lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
      .clk_16mhz (clk_16mhz),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .lock_ok   (lock_ok)
   );

   assign req.req_ready = (state_r == ST_IDLE);
   assign phase_pos = {pos_r[OUT_CLKOS3], pos_r[OUT_CLKOS2], pos_r[OUT_CLKOS], pos_r[OUT_CLKOP]};

   // Request sequencer: accept, step pulses, load pulse, settle, done
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_WAIT_LOCK;
         tmr_r        <= {TW{1'b0}};
         rem_r        <= {STEP_W{1'b0}};
         phasesel     <= OUT_CLKOP;
         phasedir     <= 1'b1;
         phasestep    <= 1'b1;
         phaseloadreg <= 1'b1;
         done         <= 1'b0;
         err_unlock   <= 1'b0;
         for (int k = 0; k < 4; k++) pos_r[k] <= {PW{1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_WAIT_LOCK: begin
               if (lock_ok) state_r <= ST_IDLE;
            end
            ST_IDLE: begin
               if (!lock_ok) begin
                  state_r <= ST_WAIT_LOCK;
               end else if (req.req_valid && req.req_ready) begin
                  phasesel   <= req.req_sel;
                  phasedir   <= req.req_dir;
                  rem_r      <= req.req_steps;
                  err_unlock <= 1'b0;
                  state_r    <= (req.req_steps == {STEP_W{1'b0}}) ? ST_DONE : ST_SETUP;
               end
            end
            default: begin
               // Lock lost mid-request: release the pins, keep completed steps.
               if (!lock_ok) begin
                  state_r      <= ST_WAIT_LOCK;
                  phasestep    <= 1'b1;
                  phaseloadreg <= 1'b1;
                  err_unlock   <= 1'b1;
               end else begin
                  case (state_r)
                     ST_SETUP: begin
                        phasestep <= 1'b0;
                        tmr_r     <= T_PULSE;
                        state_r   <= ST_STEP_LO;
                     end
                     ST_STEP_LO: begin
                        if (tmr_r == {TW{1'b0}}) begin
                           phasestep <= 1'b1;
                           tmr_r     <= T_GAP;
                           state_r   <= ST_STEP_HI;
                        end else begin
                           tmr_r <= tmr_r - TW'(1);
                        end
                     end
                     ST_STEP_HI: begin
                        if (tmr_r == {TW{1'b0}}) begin
                           rem_r           <= rem_r - STEP_W'(1);
                           pos_r[phasesel] <= pos_step(pos_r[phasesel], phasedir);
                           tmr_r           <= T_PULSE;
                           if (rem_r == STEP_W'(1)) begin
                              phaseloadreg <= 1'b0;
                              state_r      <= ST_LOAD_LO;
                           end else begin
                              phasestep <= 1'b0;
                              state_r   <= ST_STEP_LO;
                           end
                        end else begin
                           tmr_r <= tmr_r - TW'(1);
                        end
                     end
                     ST_LOAD_LO: begin
                        if (tmr_r == {TW{1'b0}}) begin
                           phaseloadreg <= 1'b1;
                           tmr_r        <= T_GAP;
                           state_r      <= ST_LOAD_HI;
                        end else begin
                           tmr_r <= tmr_r - TW'(1);
                        end
                     end
                     ST_LOAD_HI: begin
                        if (tmr_r == {TW{1'b0}}) begin
                           tmr_r   <= T_SETTLE;
                           state_r <= ST_SETTLE;
                        end else begin
                           tmr_r <= tmr_r - TW'(1);
                        end
                     end
                     ST_SETTLE: begin
                        if (tmr_r == {TW{1'b0}}) begin
                           state_r <= ST_DONE;
                        end else begin
                           tmr_r <= tmr_r - TW'(1);
                        end
                     end
                     ST_DONE: begin
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                     end
                     default: begin
                        phasestep    <= 1'b1;
                        phaseloadreg <= 1'b1;
                        state_r      <= ST_WAIT_LOCK;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule
